ddr_writeback_packer: RTL and testbench
=======================================

Name: ddr_writeback_packer

Overview:
- Output-side DDR writer. Takes 144-bit result beats from the conv unit (18 x 8-bit channels) and repacks them into 256-bit DDR write words with incrementing addresses.
- Mirror of the weight path, which reads 256-bit DDR words and widens them.
- Sits between the ConvUnit output and the DDR write channel.
- Provides a layer start, an end-of-layer flush with zero padding, and a done pulse.

Parameters:
- IN_WIDTH, 144, width of the input result beat; must be less than OUT_WIDTH.
- OUT_WIDTH, 256, width of the DDR write word.
- ADDR_WIDTH, 32, width of the DDR byte address.
- ADDR_STEP, 32, byte increment per emitted word (OUT_WIDTH/8).
- CNT_WIDTH, 20, width of the emitted-word counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a layer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first write address; latched on start.
- flush_in  in  1  pulse marking the end of layer input; sampled only in RUN.
- MAC_data_in  in  IN_WIDTH  result beat.
- MAC_data_valid_in  in  1  beat valid.
- MAC_data_ready_out  out  1  packer can accept a beat this cycle.
- DDR_data_out  out  OUT_WIDTH  write data.
- DDR_addr_out  out  ADDR_WIDTH  write address.
- DDR_valid_out  out  1  write word valid.
- DDR_ready_in  in  1  DDR accepts the word.
- word_count  out  CNT_WIDTH  words accepted by DDR in this layer.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse after the last word of the layer is accepted.
- overflow_err  out  1  sticky error: a beat was dropped.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- On reset, every output is 0, state is IDLE, fill is 0, and the buffer is 0.
- A reset asserted mid-layer aborts the layer: no done pulse, and buffered data is discarded.
- Buffer: 2*OUT_WIDTH-bit register buf with fill count 0..512, packed little-endian.
- A new beat is written at bit position fill; the first beat lands at [143:0].
- DDR_data_out = buf[255:0] and DDR_valid_out = (fill >= 256); both come straight from registers.
- DDR handshake: a word transfers on DDR_valid_out && DDR_ready_in.
  - On transfer: buf shifts right by 256, fill -= 256, DDR_addr_out += ADDR_STEP, word_count++.
  - While DDR_valid_out is high and DDR_ready_in is low, data and address must stay stable.
- Input handshake:
  - MAC_data_ready_out = (state == RUN) && (fill <= 368).
  - A beat is accepted on MAC_data_valid_in && MAC_data_ready_out.
- Simultaneous accept and emit in one cycle:
  - buf_next = (buf >> 256) | (in << (fill - 256)).
  - fill_next = fill - 112.
  - No bubble is inserted.
- Latency: the first output word is valid in the cycle after the second beat is accepted (fill = 288).
- Sustained rate: 16 input beats produce exactly 9 output words with no padding.
- Dropped beats: a valid beat while ready is low (backpressure, IDLE, FLUSH, or DONE) is dropped and sets overflow_err. overflow_err clears only on start or rst.
- State machine:
  - IDLE: on start, latch DDR_addr_out = base_addr, clear word_count and overflow_err, go to RUN.
  - RUN: accept beats and emit words. On flush_in go to FLUSH; a beat arriving in the same cycle as flush_in is still accepted.
  - FLUSH: input is blocked and full words drain.
    - If 0 < fill < 256, buf[255:fill] is forced to zero, DDR_valid_out is asserted, and fill becomes 0 on transfer.
    - When fill == 0 (including a flush of an empty buffer), go to DONE.
  - DONE: done = 1 for one cycle, then IDLE. DDR_addr_out and word_count hold their values until the next start.
- start outside IDLE is ignored. flush_in outside RUN is ignored.
- DDR_addr_out wraps modulo 2^ADDR_WIDTH. word_count wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined: adds output port stall_cnt [31:0].
  - Counts cycles with DDR_valid_out && !DDR_ready_in.
  - Clears on start and rst; saturates at 0xFFFFFFFF.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=0, RUN=1, FLUSH=2, DONE=3.
  - Width constants: IN_WIDTH = 144, OUT_WIDTH = 256, ADDR_STEP = 32.
  - Fill threshold: OUT_WIDTH*2 - IN_WIDTH.
- One sub-module, wb_gearbox: buffer, fill count, shift/insert and zero-pad datapath.
- Top level: FSM, address and word counters, error flag.

Test Plan:
- Nominal packing: start with base_addr = 0x1000, 16 beats with DDR_ready_in = 1, then flush.
  - Exactly 9 words, bit-exact concatenation of the beats.
  - Addresses run 0x1000 to 0x1100 in steps of 0x20.
  - word_count = 9 and one done pulse.
- Backpressure: DDR_ready_in low for 10 cycles while beats stream.
  - MAC_data_ready_out drops once fill > 368.
  - Held word and address stay stable; no beat is lost; overflow_err stays 0.
- Partial flush: 3 beats (432 bits), then flush.
  - Word 0 is full; word 1 has [175:0] = beat data and [255:176] = 0.
  - word_count = 2, then done.
- Drop error: MAC_data_valid_in while ready is low, and also in IDLE.
  - overflow_err = 1 and stays set; the next start clears it.
- Reset mid-layer: rst during RUN with fill = 288.
  - The next cycle has all outputs at 0 and state IDLE.
  - No done pulse; a subsequent start with base_addr = 0x2000 works normally.
- Control edge cases:
  - start during RUN is ignored and the address is unchanged.
  - flush with an empty buffer gives done two cycles after flush_in and zero DDR writes.

Source files
------------

// File: rtl/ddr_writeback_packer_pkg.sv
// Shared definitions for the DDR writeback packer.
// FSM encoding, datapath widths and the input-acceptance fill threshold.
package ddr_writeback_packer_pkg;

   localparam int IN_WIDTH    = 144;
   localparam int OUT_WIDTH   = 256;
   localparam int ADDR_WIDTH  = 32;
   localparam int ADDR_STEP   = 32;
   localparam int CNT_WIDTH   = 20;
   localparam int BUF_WIDTH   = 2 * OUT_WIDTH;
   localparam int FILL_WIDTH  = 10;
   localparam int FILL_THRESH = OUT_WIDTH * 2 - IN_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } wb_state_e;

endpackage

// File: rtl/ddr_writeback_packer_if.sv
// Beat input and DDR write channel bundle for the writeback packer.
// The slave modport is the packer side; the master modport is its environment.
interface ddr_writeback_packer_if;
   import ddr_writeback_packer_pkg::*;

   logic [IN_WIDTH-1:0]   MAC_data_in;
   logic                  MAC_data_valid_in;
   logic                  MAC_data_ready_out;
   logic [OUT_WIDTH-1:0]  DDR_data_out;
   logic [ADDR_WIDTH-1:0] DDR_addr_out;
   logic                  DDR_valid_out;
   logic                  DDR_ready_in;

   modport slave (
      input  MAC_data_in, MAC_data_valid_in, DDR_ready_in,
      output MAC_data_ready_out, DDR_data_out, DDR_addr_out, DDR_valid_out
   );

   modport master (
      output MAC_data_in, MAC_data_valid_in, DDR_ready_in,
      input  MAC_data_ready_out, DDR_data_out, DDR_addr_out, DDR_valid_out
   );

endinterface

// File: rtl/ddr_writeback_packer_gearbox.sv
// wb_gearbox: 512-bit little-endian packing buffer with fill count.
// Beats are inserted at bit position fill, full words leave from the bottom.
// Bits at and above fill are always zero, so a partial word emitted during a
// flush is already zero padded; only the valid flag has to be forced.
module wb_gearbox
   import ddr_writeback_packer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_accept,
   input  logic                  out_accept,
   input  logic                  pad_next,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   output logic [FILL_WIDTH-1:0] fill
);

   logic [BUF_WIDTH-1:0]  buf_q, buf_base, buf_next;
   logic [FILL_WIDTH-1:0] fill_q, fill_base, fill_next;
   logic                  valid_q, valid_next;

   // Next buffer contents: drop the emitted word first, then insert the new beat.
   always_comb begin
      buf_base  = buf_q;
      fill_base = fill_q;
      if (out_accept) begin
         buf_base  = buf_q >> OUT_WIDTH;
         fill_base = (fill_q >= FILL_WIDTH'(OUT_WIDTH)) ? fill_q - FILL_WIDTH'(OUT_WIDTH) : '0;
      end
      buf_next  = buf_base;
      fill_next = fill_base;
      if (in_accept) begin
         buf_next  = buf_base | (BUF_WIDTH'(in_data) << fill_base);
         fill_next = fill_base + FILL_WIDTH'(IN_WIDTH);
      end
      valid_next = (fill_next >= FILL_WIDTH'(OUT_WIDTH)) || (pad_next && (fill_next != '0));
   end

   // Buffer, fill count and registered output-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q   <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         buf_q   <= buf_next;
         fill_q  <= fill_next;
         valid_q <= valid_next;
      end
   end

   assign out_data  = buf_q[OUT_WIDTH-1:0];
   assign out_valid = valid_q;
   assign fill      = fill_q;

endmodule

// File: rtl/ddr_writeback_packer.sv
// ddr_writeback_packer: repacks 144-bit conv results into 256-bit DDR writes.
// Layer control FSM, write address and word counters, sticky drop flag.
// Optional macro WB_PERF_CNT_EN adds the stall_cnt performance counter port.
module ddr_writeback_packer
   import ddr_writeback_packer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  flush_in,
   ddr_writeback_packer_if.slave bus,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow_err
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   wb_state_e             state_q, state_d;
   logic [FILL_WIDTH-1:0] fill;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  err_q;
   logic                  xfer, accept, drop, start_fire;

   assign bus.MAC_data_ready_out = (state_q == RUN) && (fill <= FILL_WIDTH'(FILL_THRESH));
   assign xfer       = bus.DDR_valid_out && bus.DDR_ready_in;
   assign accept     = bus.MAC_data_valid_in && bus.MAC_data_ready_out;
   assign drop       = bus.MAC_data_valid_in && !bus.MAC_data_ready_out;
   assign start_fire = (state_q == IDLE) && start;

   wb_gearbox u_gearbox (
      .clk        (clk),
      .rst        (rst),
      .in_data    (bus.MAC_data_in),
      .in_accept  (accept),
      .out_accept (xfer),
      .pad_next   (state_d == FLUSH),
      .out_data   (bus.DDR_data_out),
      .out_valid  (bus.DDR_valid_out),
      .fill       (fill)
   );

   // Layer state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Layer sequencing: start opens a layer, flush drains it, done closes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)       state_d = RUN;
         RUN:     if (flush_in)    state_d = FLUSH;
         FLUSH:   if (fill == '0)  state_d = DONE;
         DONE:                     state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Write address, accepted-word count and sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (start_fire) begin
            addr_q  <= base_addr;
            count_q <= '0;
         end else if (xfer) begin
            addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            count_q <= count_q + CNT_WIDTH'(1);
         end
         if (drop)            err_q <= 1'b1;
         else if (start_fire) err_q <= 1'b0;
      end
   end

`ifdef WB_PERF_CNT_EN
   // Saturating count of cycles a word waits on DDR backpressure.
   always_ff @(posedge clk) begin
      if (rst || start_fire)                                   stall_cnt <= '0;
      else if (bus.DDR_valid_out && !bus.DDR_ready_in && (stall_cnt != 32'hFFFF_FFFF))
                                                               stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   assign bus.DDR_addr_out = addr_q;
   assign word_count       = count_q;
   assign overflow_err     = err_q;
   assign busy             = (state_q == RUN) || (state_q == FLUSH);
   assign done             = (state_q == DONE);

endmodule

// File: tb/tb_ddr_writeback_packer.sv
// Scoreboard bench for ddr_writeback_packer: expected DDR words are pushed when
// a layer's beats are issued; a negedge monitor pops and compares on every write.
module tb_ddr_writeback_packer;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush_in = 1'b0;
   logic [31:0] base_addr = '0;
   logic [19:0] word_count;
   logic        busy, done, overflow_err;
`ifdef WB_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   exp_t        exp_q[$];
   int          vec_count = 0;
   int          err_count = 0;
   int          done_count = 0;
   bit          mon_en = 1'b1;
   bit          prev_stall = 1'b0;
   logic [255:0] prev_data;
   logic [31:0]  prev_addr;

   ddr_writeback_packer_if bus();

   ddr_writeback_packer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .flush_in     (flush_in),
      .bus          (bus),
      .word_count   (word_count),
      .busy         (busy),
      .done         (done),
      .overflow_err (overflow_err)
`ifdef WB_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      vec_count++;
      if (act !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [143:0] makeBeat(input int seed);
      logic [143:0] b;
      for (int k = 0; k < 18; k++) b[k*8 +: 8] = 8'(seed * 37 + k * 11 + 5);
      return b;
   endfunction

   // Bit-exact concatenation of the beats, cut into zero-padded 256-bit words.
   task automatic buildExpected(input int seed, input int nbeats, input logic [31:0] base);
      logic [2303:0] stream;
      exp_t          e;
      int            nwords;
      stream = '0;
      for (int i = 0; i < nbeats; i++) stream |= 2304'(makeBeat(seed + i)) << (i * 144);
      nwords = (nbeats * 144 + 255) / 256;
      for (int w = 0; w < nwords; w++) begin
         e.data = stream[w*256 +: 256];
         e.addr = base + 32'(w * 32);
         exp_q.push_back(e);
      end
   endtask

   // Presents one beat only once ready is seen, so no beat is ever dropped.
   task automatic sendBeat(input logic [143:0] beat);
      int n = 0;
      @(negedge clk);
      while (!bus.MAC_data_ready_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.MAC_data_ready_out) begin
         vec_count++;
         err_count++;
         $display("[TB] FAIL beat_ready_timeout: got ready 0 expected 1");
         return;
      end
      bus.MAC_data_in       = beat;
      bus.MAC_data_valid_in = 1'b1;
      @(posedge clk);
      #1 bus.MAC_data_valid_in = 1'b0;
   endtask

   task automatic applyStimulus(input int seed, input int first, input int nbeats);
      for (int i = first; i < first + nbeats; i++) sendBeat(makeBeat(seed + i));
   endtask

   task automatic startLayer(input logic [31:0] base);
      start     = 1'b1;
      base_addr = base;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic flushLayer();
      flush_in = 1'b1;
      @(posedge clk);
      #1 flush_in = 1'b0;
   endtask

   task automatic waitDone(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      checkOutput(name, 256'(seen), 256'(1));
      @(posedge clk);
      #1 checkOutput({name, "_pulse_end"}, 256'(done), 256'(0));
   endtask

   // Scoreboard monitor plus hold-stability check while a word is stalled.
   always @(negedge clk) begin
      exp_t e;
      if (done) done_count++;
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("hold_data", bus.DDR_data_out, prev_data);
            checkOutput("hold_addr", 256'(bus.DDR_addr_out), 256'(prev_addr));
         end
         if (bus.DDR_valid_out && bus.DDR_ready_in) begin
            if (exp_q.size() == 0) begin
               vec_count++;
               err_count++;
               $display("[TB] FAIL unexpected_word: got addr %h expected no write", bus.DDR_addr_out);
            end else begin
               e = exp_q.pop_front();
               checkOutput("word_data", bus.DDR_data_out, e.data);
               checkOutput("word_addr", 256'(bus.DDR_addr_out), 256'(e.addr));
            end
         end
         prev_stall = bus.DDR_valid_out && !bus.DDR_ready_in;
         prev_data  = bus.DDR_data_out;
         prev_addr  = bus.DDR_addr_out;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dc;
      bus.MAC_data_in       = '0;
      bus.MAC_data_valid_in = 1'b0;
      bus.DDR_ready_in      = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ddr_valid", 256'(bus.DDR_valid_out), 256'(0));
      checkOutput("rst_mac_ready", 256'(bus.MAC_data_ready_out), 256'(0));
      checkOutput("rst_ddr_data", bus.DDR_data_out, 256'(0));
      checkOutput("rst_addr", 256'(bus.DDR_addr_out), 256'(0));
      checkOutput("rst_word_count", 256'(word_count), 256'(0));
      checkOutput("rst_busy", 256'(busy), 256'(0));
      checkOutput("rst_done", 256'(done), 256'(0));
      checkOutput("rst_overflow", 256'(overflow_err), 256'(0));
      rst = 1'b0;

      // Nominal: 16 beats -> 9 words at 0x1000..0x1100
      $display("[TB] nominal packing");
      buildExpected(10, 16, 32'h1000);
      startLayer(32'h1000);
      checkOutput("nom_busy", 256'(busy), 256'(1));
      applyStimulus(10, 0, 1);
      checkOutput("latency_beat0", 256'(bus.DDR_valid_out), 256'(0));
      applyStimulus(10, 1, 1);
      checkOutput("latency_beat1", 256'(bus.DDR_valid_out), 256'(1));
      applyStimulus(10, 2, 14);
      flushLayer();
      waitDone("nom_done");
      checkOutput("nom_word_count", 256'(word_count), 256'(9));
      checkOutput("nom_addr_end", 256'(bus.DDR_addr_out), 256'(32'h1120));
      checkOutput("nom_queue", 256'(exp_q.size()), 256'(0));
      checkOutput("nom_busy_end", 256'(busy), 256'(0));

      // Backpressure: DDR stalls, input throttles above fill 368
      $display("[TB] backpressure");
      buildExpected(40, 8, 32'h3000);
      startLayer(32'h3000);
      bus.DDR_ready_in = 1'b0;
      applyStimulus(40, 0, 3);
      checkOutput("bp_mac_ready_low", 256'(bus.MAC_data_ready_out), 256'(0));
      checkOutput("bp_valid_held", 256'(bus.DDR_valid_out), 256'(1));
      repeat (8) @(posedge clk);
      #1;
      checkOutput("bp_word_count", 256'(word_count), 256'(0));
      checkOutput("bp_overflow", 256'(overflow_err), 256'(0));
      bus.DDR_ready_in = 1'b1;
      applyStimulus(40, 3, 5);
      flushLayer();
      waitDone("bp_done");
      checkOutput("bp_word_count_end", 256'(word_count), 256'(5));
      checkOutput("bp_queue", 256'(exp_q.size()), 256'(0));
      checkOutput("bp_overflow_end", 256'(overflow_err), 256'(0));

      // Partial flush: 3 beats -> full word plus zero-padded word
      $display("[TB] partial flush");
      buildExpected(70, 3, 32'h4000);
      startLayer(32'h4000);
      applyStimulus(70, 0, 3);
      flushLayer();
      waitDone("part_done");
      checkOutput("part_word_count", 256'(word_count), 256'(2));
      checkOutput("part_queue", 256'(exp_q.size()), 256'(0));

      // Drop errors in IDLE and under backpressure
      $display("[TB] drop error");
      bus.MAC_data_in       = makeBeat(99);
      bus.MAC_data_valid_in = 1'b1;
      @(posedge clk);
      #1 bus.MAC_data_valid_in = 1'b0;
      checkOutput("drop_idle", 256'(overflow_err), 256'(1));
      startLayer(32'h4800);
      checkOutput("drop_cleared", 256'(overflow_err), 256'(0));
      buildExpected(90, 3, 32'h4800);
      bus.DDR_ready_in = 1'b0;
      applyStimulus(90, 0, 3);
      bus.MAC_data_in       = makeBeat(200);
      bus.MAC_data_valid_in = 1'b1;
      @(posedge clk);
      #1 bus.MAC_data_valid_in = 1'b0;
      checkOutput("drop_run", 256'(overflow_err), 256'(1));
      repeat (2) @(posedge clk);
      #1 bus.DDR_ready_in = 1'b1;
      flushLayer();
      waitDone("drop_done");
      checkOutput("drop_sticky", 256'(overflow_err), 256'(1));
      checkOutput("drop_queue", 256'(exp_q.size()), 256'(0));

      // Reset mid-layer with fill = 288
      $display("[TB] reset mid-layer");
      startLayer(32'h5000);
      bus.DDR_ready_in = 1'b0;
      applyStimulus(110, 0, 2);
      checkOutput("mid_valid_pre", 256'(bus.DDR_valid_out), 256'(1));
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("mid_valid", 256'(bus.DDR_valid_out), 256'(0));
      checkOutput("mid_data", bus.DDR_data_out, 256'(0));
      checkOutput("mid_addr", 256'(bus.DDR_addr_out), 256'(0));
      checkOutput("mid_word_count", 256'(word_count), 256'(0));
      checkOutput("mid_busy", 256'(busy), 256'(0));
      checkOutput("mid_mac_ready", 256'(bus.MAC_data_ready_out), 256'(0));
      dc = done_count;
      repeat (3) @(posedge clk);
      #1 checkOutput("mid_no_done", 256'(done_count), 256'(dc));
      mon_en = 1'b1;
      bus.DDR_ready_in = 1'b1;
      buildExpected(120, 2, 32'h2000);
      startLayer(32'h2000);
      applyStimulus(120, 0, 2);
      flushLayer();
      waitDone("mid_restart_done");
      checkOutput("mid_restart_count", 256'(word_count), 256'(2));

      // start during RUN is ignored
      $display("[TB] control edges");
      startLayer(32'h6000);
      startLayer(32'h7000);
      checkOutput("run_start_ignored", 256'(bus.DDR_addr_out), 256'(32'h6000));
      buildExpected(130, 2, 32'h6000);
      applyStimulus(130, 0, 2);
      flushLayer();
      waitDone("run_start_done");

      // Empty flush: done exactly two cycles after flush_in, no writes
      startLayer(32'h8000);
      flushLayer();
      checkOutput("empty_flush_cyc1", 256'(done), 256'(0));
      @(posedge clk);
      #1 checkOutput("empty_flush_cyc2", 256'(done), 256'(1));
      @(posedge clk);
      #1 checkOutput("empty_flush_cyc3", 256'(done), 256'(0));
      checkOutput("empty_word_count", 256'(word_count), 256'(0));
      checkOutput("empty_addr", 256'(bus.DDR_addr_out), 256'(32'h8000));

      repeat (3) @(posedge clk);
      #1 checkOutput("final_queue", 256'(exp_q.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
